// File: rtl/addsub_result_stage.sv
// addsub_result_stage: registers adder sum/carry with N/Z/V/C flags into a small handshake FIFO and tracks overflow events.
module addsub_result_stage #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic             op_sub,
    input  logic [W-1:0]     sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c,
    input  logic             clr_sticky,
    output logic             v_sticky,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = W + 4;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, v_in;
    logic [EW-1:0] entry;
    always_comb begin
        in_ready  = rst_n && (count != FULL);
        out_valid = count != '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        v_in      = ~(op_a[W-1] ^ op_b[W-1] ^ op_sub) & (sum[W-1] ^ op_a[W-1]);
        entry     = {sum, sum[W-1], sum == '0, v_in, cout};
        {result, flag_n, flag_z, flag_v, flag_c} = mem[rd_ptr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            v_sticky  <= 1'b0;
            ovf_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            // an overflow push coinciding with a clear restarts the count at one
            if (push && v_in) begin
                v_sticky  <= 1'b1;
                ovf_count <= clr_sticky ? CNT_W'(1) : (&ovf_count ? ovf_count : ovf_count + 1'b1);
            end else if (clr_sticky) begin
                v_sticky  <= 1'b0;
                ovf_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage: scoreboard bench for the adder result/flag FIFO stage.
module tb_addsub_result_stage;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, op_sub, cout, out_valid, out_ready;
    logic [7:0] op_a, op_b, sum, result, ovf_count;
    logic       flag_n, flag_z, flag_v, flag_c, clr_sticky, v_sticky;
    logic [11:0] exp_q[$], obs_q[$];
    logic [11:0] e, o;
    int checks = 0, errors = 0;

    addsub_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .sum(sum), .cout(cout),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .clr_sticky(clr_sticky), .v_sticky(v_sticky), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int r;
        logic [7:0] s;
        logic c, v;
        r = sub ? $signed(a) - $signed(b) : $signed(a) + $signed(b);
        s = r[7:0];
        c = sub ? (a >= b) : (int'(a) + int'(b) > 255);
        v = (r > 127) || (r < -128);
        return {s, s[7], s == 8'h00, v, c};
    endfunction

    task automatic set_in(input logic valid, input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic [8:0] t;
        in_valid = valid;
        if (valid) begin
            t = sub ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
            op_a = a; op_b = b; op_sub = sub; {cout, sum} = t;
        end else begin
            op_a = 'x; op_b = 'x; op_sub = 1'bx; sum = 'x; cout = 1'bx;
        end
    endtask

    // capture handshakes mid-cycle, then advance to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b, op_sub));
        if (out_valid && out_ready) obs_q.push_back({result, flag_n, flag_z, flag_v, flag_c});
        @(posedge clk);
        #1;
    endtask

    task automatic flush_out();
        out_ready = 1'b1;
        set_in(1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8 && out_valid; i++) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_timeout: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        set_in(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, flag_n, flag_z, flag_v, flag_c, v_sticky, ovf_count} !== 22'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b res=%h nzvc=%b%b%b%b stk=%b cnt=%0d required all 0",
                     in_ready, out_valid, result, flag_n, flag_z, flag_v, flag_c, v_sticky, ovf_count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        set_in(1'b1, 8'h7F, 8'h01, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid=%b required 1", out_valid); end
        checks++;
        if ({v_sticky, ovf_count} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL add_sticky: v_sticky=%b ovf_count=%0d required 1/1", v_sticky, ovf_count);
        end
        checks++;
        if ({result, flag_n, flag_z, flag_v, flag_c} !== 12'h80A) begin
            errors++; $display("FAIL add_head: got %h required 80a", {result, flag_n, flag_z, flag_v, flag_c});
        end
        flush_out();
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL add_data: got %h required %h", o, e); end
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        set_in(1'b1, 8'h05, 8'h05, 1'b1);
        tick();
        set_in(1'b1, 8'h80, 8'h01, 1'b1);
        tick();
        flush_out();
        checks++;
        if (exp_q.size() != 2 || exp_q[0] !== 12'h005 || exp_q[1] !== 12'h7F3) begin
            errors++; $display("FAIL sub_model: %0d entries queued, required 005 then 7f3", exp_q.size());
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL sub_data: got %h required %h", o, e); end
        end
        checks++;
        if (ovf_count !== 8'd2) begin errors++; $display("FAIL sub_ovf_count: got %0d required 2", ovf_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1'b1, 8'h10, 8'h20, 1'b0);
        tick();
        set_in(1'b1, 8'h90, 8'h90, 1'b0);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: in_ready=%b required 0", in_ready); end
        set_in(1'b1, 8'h33, 8'h44, 1'b1);
        repeat (2) tick();
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++; $display("FAIL full_hold: in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: in_ready=%b required 1", in_ready); end
        tick();
        flush_out();
        checks++;
        if (obs_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d outputs required 3", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL bp_data: got %h required %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        out_ready = 1'b0;
        set_in(1'b1, 8'hC8, 8'h64, 1'b1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 8'(i * 23); b = 8'(i * 7 + 3);
            set_in(1'b1, a, b, i[0]);
            tick();
            checks++;
            if ({out_valid, in_ready} !== 2'b11) begin
                errors++; $display("FAIL b2b_cycle%0d: out_valid=%b in_ready=%b required 1/1", i, out_valid, in_ready);
            end
        end
        flush_out();
        checks++;
        if (obs_q.size() != 11) begin errors++; $display("FAIL b2b_count: got %0d outputs required 11", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_data: got %h required %h", o, e); end
        end
    endtask

    task automatic test_sticky();
        out_ready = 1'b1;
        clr_sticky = 1'b1;
        set_in(1'b1, 8'h7F, 8'h01, 1'b0);
        tick();
        clr_sticky = 1'b0;
        set_in(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if ({v_sticky, ovf_count} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL clr_with_set: v_sticky=%b ovf_count=%0d required 1/1", v_sticky, ovf_count);
        end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++;
        if ({v_sticky, ovf_count} !== 9'h0) begin
            errors++; $display("FAIL clr_alone: v_sticky=%b ovf_count=%0d required 0/0", v_sticky, ovf_count);
        end
        for (int i = 0; i < 300; i++) begin
            set_in(1'b1, 8'h40 + 8'(i % 64), 8'h40, 1'b0);
            tick();
            if (i == 254) begin
                checks++;
                if (ovf_count !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d required 255", ovf_count); end
            end
        end
        checks++;
        if ({v_sticky, ovf_count} !== {1'b1, 8'd255}) begin
            errors++; $display("FAIL sat_hold: v_sticky=%b ovf_count=%0d required 1/255", v_sticky, ovf_count);
        end
        flush_out();
        checks++;
        if (obs_q.size() != 301) begin errors++; $display("FAIL sticky_count: got %0d outputs required 301", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL sticky_data: got %h required %h", o, e); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(1'b1, 8'h11, 8'h22, 1'b0);
        tick();
        set_in(1'b1, 8'h7F, 8'h7F, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if ({out_valid, in_ready, v_sticky} !== 3'b101) begin
            errors++; $display("FAIL pre_reset: out_valid=%b in_ready=%b v_sticky=%b required 1/0/1", out_valid, in_ready, v_sticky);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++; $display("FAIL async_drop: out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_reset: in_ready=%b required 0", in_ready); end
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, v_sticky, ovf_count} !== {2'b10, 9'h0}) begin
            errors++; $display("FAIL post_reset: in_ready=%b out_valid=%b v_sticky=%b ovf_count=%0d required 1/0/0/0",
                               in_ready, out_valid, v_sticky, ovf_count);
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL reset_discard: got %0d outputs required 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_sticky();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
